// File: rtl/pipe_field_animator.sv
// ---------------------------------------------------------------------------
// pipe_field_animator
//
// Manages NUM_PIPES independent pipe obstacles that scroll right-to-left.
// Horizontal position is tracked in 1/FRAC_SCALE pixel fixed point.
// A spawn request claims the lowest free slot, subject to a minimum spacing
// of SPAWN_GAP frames between accepted spawns. Each slot latches the score
// at spawn time, and that latched score sets the slot's scroll speed and
// gap size. Slots that pass the left edge are retired and reported.
//
// Ports:
//   animationCLOCK  frame clock, one rising edge per animation frame
//   reset           synchronous, active-high
//   spawn           spawn request, sampled every edge
//   pointY          gap centre Y for a newly spawned pipe
//   score           current game score
//   pipeX           per-slot X in pixels, slot i at [10i+9:10i]
//   pipeDownY       per-slot down-pipe top Y
//   pipeUpSkipY     per-slot up-pipe image rows to skip
//   downVisible     per-slot down-pipe visible
//   upVisible       per-slot up-pipe visible
//   spawnAccepted   one-frame pulse when a spawn was taken
//   endOfMapPipe    one-frame pulse when at least one slot retired
//   retireCount     number of slots retired, valid with endOfMapPipe
//   activeCount     number of enabled slots
//   full            all slots enabled
// ---------------------------------------------------------------------------
module pipe_field_animator #(
    parameter int NUM_PIPES        = 3,
    parameter int FRAC_SCALE       = 100,
    parameter int SPAWN_X          = 650,
    parameter int MIN_SPEED        = 280,
    parameter int SPEED_PER_SCORE  = 25,
    parameter int DOUBLE_MIN_SCORE = 10,
    parameter int BASE_SPACE       = 175,
    parameter int MIN_SPACE        = 150,
    parameter int SPACE_RED        = 20,
    parameter int SCREEN_MID       = 240,
    parameter int PIPE_UP_IMG      = 402,
    parameter int SPAWN_GAP        = 40
) (
    input  logic                      animationCLOCK,
    input  logic                      reset,
    input  logic                      spawn,
    input  logic [9:0]                pointY,
    input  logic [9:0]                score,
    output logic [10*NUM_PIPES-1:0]   pipeX,
    output logic [10*NUM_PIPES-1:0]   pipeDownY,
    output logic [10*NUM_PIPES-1:0]   pipeUpSkipY,
    output logic [NUM_PIPES-1:0]      downVisible,
    output logic [NUM_PIPES-1:0]      upVisible,
    output logic                      spawnAccepted,
    output logic                      endOfMapPipe,
    output logic [3:0]                retireCount,
    output logic [3:0]                activeCount,
    output logic                      full
);

    // Per-slot state
    logic [NUM_PIPES-1:0] en;
    logic [19:0]          pos_x [NUM_PIPES];
    logic [9:0]           pos_y [NUM_PIPES];
    logic [9:0]           sc    [NUM_PIPES];
    logic [15:0]          cooldown;

    // Per-slot combinational helpers
    logic [19:0]          step     [NUM_PIPES];
    logic [NUM_PIPES-1:0] retiring;

    // Spawn allocation
    logic                 free_found;
    logic [3:0]           free_idx;
    logic                 accept;
    logic [3:0]           retire_num;
    logic [3:0]           active_num;

    // Lowest free slot wins: scanning downward lets the last hit be the lowest.
    // Only the registered enables count, so a slot retiring on this edge is
    // still busy and cannot be reused until the following edge.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 4'd0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (!en[i]) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    assign accept = spawn && (cooldown == 16'd0) && free_found;

    // Population counts of retiring and enabled slots
    always_comb begin
        retire_num = 4'd0;
        active_num = 4'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            retire_num = retire_num + {3'b000, retiring[i]};
            active_num = active_num + {3'b000, en[i]};
        end
    end

    assign activeCount = active_num;
    assign full        = &en;

    genvar g;
    generate
        for (g = 0; g < NUM_PIPES; g++) begin : g_slot
            logic [19:0] red;
            logic [9:0]  space;
            logic [9:0]  half;
            logic [9:0]  top;
            logic [10:0] down_sum;

            assign step[g] = (20'(sc[g]) + 20'd1) * 20'(SPEED_PER_SCORE)
                             + 20'(MIN_SPEED);
            assign retiring[g] = en[g] && (pos_x[g] < step[g]);

            // Gap shrinks with score above the two-pipe threshold, floored.
            // Below the threshold only one pipe is shown, so no gap applies.
            always_comb begin
                red   = 20'(sc[g] - 10'(DOUBLE_MIN_SCORE)) * 20'(SPACE_RED);
                space = 10'd0;
                if (sc[g] >= 10'(DOUBLE_MIN_SCORE)) begin
                    if (red > 20'(BASE_SPACE - MIN_SPACE))
                        space = 10'(MIN_SPACE);
                    else
                        space = 10'(BASE_SPACE) - red[9:0];
                end
            end

            assign half     = space >> 1;
            assign down_sum = {1'b0, pos_y[g]} + {1'b0, half};
            assign top      = (pos_y[g] > half) ? (pos_y[g] - half) : 10'd0;

            assign pipeX[10*g +: 10]       = 10'(pos_x[g] / 20'(FRAC_SCALE));
            assign pipeDownY[10*g +: 10]   = down_sum[10] ? 10'd1023 : down_sum[9:0];
            assign pipeUpSkipY[10*g +: 10] = 10'(PIPE_UP_IMG) - top;

            // In single-pipe mode the gap centre picks which pipe appears
            assign downVisible[g] = (sc[g] >= 10'(DOUBLE_MIN_SCORE)) ? en[g]
                                    : (en[g] && (pos_y[g] <  10'(SCREEN_MID)));
            assign upVisible[g]   = (sc[g] >= 10'(DOUBLE_MIN_SCORE)) ? en[g]
                                    : (en[g] && (pos_y[g] >= 10'(SCREEN_MID)));
        end
    endgenerate

    // Slot motion, retirement, spawn loading and the cooldown timer.
    // A retiring slot is cleared in the same frame it passes the edge and the
    // retirement is reported as a registered pulse in the following frame.
    always_ff @(posedge animationCLOCK) begin
        if (reset) begin
            en            <= '0;
            cooldown      <= 16'd0;
            spawnAccepted <= 1'b0;
            endOfMapPipe  <= 1'b0;
            retireCount   <= 4'd0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pos_x[i] <= 20'd0;
                pos_y[i] <= 10'd0;
                sc[i]    <= 10'd0;
            end
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                if (en[i]) begin
                    if (retiring[i]) begin
                        en[i]    <= 1'b0;
                        pos_x[i] <= 20'd0;
                    end else begin
                        pos_x[i] <= pos_x[i] - step[i];
                    end
                end else if (accept && (free_idx == 4'(i))) begin
                    en[i]    <= 1'b1;
                    pos_x[i] <= 20'(SPAWN_X * FRAC_SCALE);
                    pos_y[i] <= pointY;
                    sc[i]    <= score;
                end
            end

            if (accept)
                cooldown <= 16'(SPAWN_GAP - 1);
            else if (cooldown != 16'd0)
                cooldown <= cooldown - 16'd1;

            spawnAccepted <= accept;
            endOfMapPipe  <= (retire_num != 4'd0);
            retireCount   <= retire_num;
        end
    end

endmodule

// File: tb/tb_pipe_field_animator.sv
// ---------------------------------------------------------------------------
// tb_pipe_field_animator
//
// Directed bench for pipe_field_animator. The main instance uses the default
// parameters. A second instance with a one-frame spawn spacing launches two
// slots back to back so that both retire on the same frame.
// ---------------------------------------------------------------------------
module tb_pipe_field_animator;

    logic        animationCLOCK = 1'b0;
    logic        reset;
    logic        spawn;
    logic [9:0]  pointY;
    logic [9:0]  score;
    logic [29:0] pipeX;
    logic [29:0] pipeDownY;
    logic [29:0] pipeUpSkipY;
    logic [2:0]  downVisible;
    logic [2:0]  upVisible;
    logic        spawnAccepted;
    logic        endOfMapPipe;
    logic [3:0]  retireCount;
    logic [3:0]  activeCount;
    logic        full;

    logic        reset_b;
    logic        spawn_b;
    logic [9:0]  pointY_b;
    logic [9:0]  score_b;
    logic [29:0] pipeX_b;
    logic [29:0] pipeDownY_b;
    logic [29:0] pipeUpSkipY_b;
    logic [2:0]  downVisible_b;
    logic [2:0]  upVisible_b;
    logic        spawnAccepted_b;
    logic        endOfMapPipe_b;
    logic [3:0]  retireCount_b;
    logic [3:0]  activeCount_b;
    logic        full_b;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 animationCLOCK = ~animationCLOCK;

    pipe_field_animator dut (
        .animationCLOCK (animationCLOCK),
        .reset          (reset),
        .spawn          (spawn),
        .pointY         (pointY),
        .score          (score),
        .pipeX          (pipeX),
        .pipeDownY      (pipeDownY),
        .pipeUpSkipY    (pipeUpSkipY),
        .downVisible    (downVisible),
        .upVisible      (upVisible),
        .spawnAccepted  (spawnAccepted),
        .endOfMapPipe   (endOfMapPipe),
        .retireCount    (retireCount),
        .activeCount    (activeCount),
        .full           (full)
    );

    pipe_field_animator #(.SPAWN_GAP(1)) dut_b2b (
        .animationCLOCK (animationCLOCK),
        .reset          (reset_b),
        .spawn          (spawn_b),
        .pointY         (pointY_b),
        .score          (score_b),
        .pipeX          (pipeX_b),
        .pipeDownY      (pipeDownY_b),
        .pipeUpSkipY    (pipeUpSkipY_b),
        .downVisible    (downVisible_b),
        .upVisible      (upVisible_b),
        .spawnAccepted  (spawnAccepted_b),
        .endOfMapPipe   (endOfMapPipe_b),
        .retireCount    (retireCount_b),
        .activeCount    (activeCount_b),
        .full           (full_b)
    );

    // Compares one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Advances one frame; outputs are sampled 1 time unit after the edge
    task automatic nextFrame();
        @(posedge animationCLOCK);
        #1;
    endtask

    // Drives the main instance's inputs and advances one frame
    task automatic applyStimulus(input logic rst, input logic sp,
                                 input logic [9:0] sc, input logic [9:0] py);
        reset  = rst;
        spawn  = sp;
        score  = sc;
        pointY = py;
        nextFrame();
    endtask

    initial begin
        logic exp_acc;
        reset    = 1'b1;
        spawn    = 1'b0;
        score    = 10'd0;
        pointY   = 10'd0;
        reset_b  = 1'b1;
        spawn_b  = 1'b0;
        score_b  = 10'd0;
        pointY_b = 10'd0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd0);
        checkOutput("rst activeCount", activeCount, 0);
        checkOutput("rst full", full, 0);
        checkOutput("rst pipeX", pipeX, 0);
        checkOutput("rst downVisible", downVisible, 0);
        checkOutput("rst upVisible", upVisible, 0);
        checkOutput("rst spawnAccepted", spawnAccepted, 0);
        checkOutput("rst endOfMapPipe", endOfMapPipe, 0);
        checkOutput("rst retireCount", retireCount, 0);

        // Single spawn at score 0: step 305 subpixels per frame
        applyStimulus(1'b0, 1'b1, 10'd0, 10'd100);
        checkOutput("s1 spawnAccepted", spawnAccepted, 1);
        checkOutput("s1 pipeX0 at spawn", pipeX[9:0], 650);
        checkOutput("s1 activeCount", activeCount, 1);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd100);
        checkOutput("s1 pipeX0 frame1", pipeX[9:0], 646);
        checkOutput("s1 spawnAccepted drop", spawnAccepted, 0);
        checkOutput("s1 downVisible", downVisible, 3'b001);
        checkOutput("s1 upVisible", upVisible, 3'b000);
        checkOutput("s1 pipeDownY0", pipeDownY[9:0], 100);
        checkOutput("s1 pipeUpSkipY0", pipeUpSkipY[9:0], 302);
        repeat (212) applyStimulus(1'b0, 1'b0, 10'd0, 10'd100);
        checkOutput("s1 edge213 endOfMapPipe", endOfMapPipe, 0);
        checkOutput("s1 edge213 activeCount", activeCount, 1);
        checkOutput("s1 edge213 pipeX0", pipeX[9:0], 0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd100);
        checkOutput("s1 edge214 endOfMapPipe", endOfMapPipe, 1);
        checkOutput("s1 edge214 retireCount", retireCount, 1);
        checkOutput("s1 edge214 activeCount", activeCount, 0);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd100);
        checkOutput("s1 edge215 endOfMapPipe", endOfMapPipe, 0);
        checkOutput("s1 edge215 retireCount", retireCount, 0);

        // Gap sizes: score 11 -> 155, score 12 -> 150 (floor), score 10 -> 175
        applyStimulus(1'b0, 1'b1, 10'd11, 10'd200);
        checkOutput("gap11 spawnAccepted", spawnAccepted, 1);
        checkOutput("gap11 pipeDownY0", pipeDownY[9:0], 277);
        checkOutput("gap11 pipeUpSkipY0", pipeUpSkipY[9:0], 279);
        checkOutput("gap11 downVisible0", downVisible[0], 1);
        checkOutput("gap11 upVisible0", upVisible[0], 1);
        repeat (39) applyStimulus(1'b0, 1'b0, 10'd12, 10'd200);
        applyStimulus(1'b0, 1'b1, 10'd12, 10'd200);
        checkOutput("gap12 spawnAccepted", spawnAccepted, 1);
        checkOutput("gap12 pipeDownY1", pipeDownY[19:10], 275);
        checkOutput("gap12 pipeUpSkipY1", pipeUpSkipY[19:10], 277);
        repeat (39) applyStimulus(1'b0, 1'b0, 10'd10, 10'd300);
        applyStimulus(1'b0, 1'b1, 10'd10, 10'd300);
        checkOutput("gap10 spawnAccepted", spawnAccepted, 1);
        checkOutput("gap10 pipeDownY2", pipeDownY[29:20], 387);
        checkOutput("gap10 pipeUpSkipY2", pipeUpSkipY[29:20], 189);
        checkOutput("gap10 visible both", {downVisible[2], upVisible[2]}, 2'b11);
        checkOutput("gap10 full", full, 1);
        checkOutput("gap10 activeCount", activeCount, 3);

        // Reset with three slots active, then spawn right after
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd100);
        checkOutput("midrst activeCount", activeCount, 0);
        checkOutput("midrst downVisible", downVisible, 0);
        checkOutput("midrst upVisible", upVisible, 0);
        checkOutput("midrst endOfMapPipe", endOfMapPipe, 0);
        checkOutput("midrst pipeX", pipeX, 0);
        applyStimulus(1'b0, 1'b1, 10'd0, 10'd100);
        checkOutput("postrst spawnAccepted", spawnAccepted, 1);
        checkOutput("postrst pipeX0", pipeX[9:0], 650);
        checkOutput("postrst pipeX1", pipeX[19:10], 0);
        checkOutput("postrst activeCount", activeCount, 1);

        // Spawn held high: accepts at 0, 40, 80; dropped while full until
        // slot 0 retires at 214, then slot 0 is reused at 215
        applyStimulus(1'b1, 1'b0, 10'd0, 10'd300);
        reset  = 1'b0;
        spawn  = 1'b1;
        score  = 10'd0;
        pointY = 10'd300;
        for (int f = 0; f <= 215; f++) begin
            nextFrame();
            exp_acc = (f == 0) || (f == 40) || (f == 80) || (f == 215);
            checkOutput($sformatf("hold accept f%0d", f), spawnAccepted, exp_acc);
            if (f == 0)
                checkOutput("hold upVisible0", upVisible[0], 1);
            if (f == 40)
                checkOutput("hold pipeX1 f40", pipeX[19:10], 650);
            if (f == 79)
                checkOutput("hold full f79", full, 0);
            if (f == 80) begin
                checkOutput("hold full f80", full, 1);
                checkOutput("hold pipeX2 f80", pipeX[29:20], 650);
            end
            if (f == 214) begin
                checkOutput("hold endOfMapPipe f214", endOfMapPipe, 1);
                checkOutput("hold activeCount f214", activeCount, 2);
            end
            if (f == 215) begin
                checkOutput("hold pipeX0 f215", pipeX[9:0], 650);
                checkOutput("hold activeCount f215", activeCount, 3);
            end
        end
        spawn = 1'b0;

        // Back-to-back spawns: score 100 (step 2805) then score 104
        // (step 2905) one frame later both retire on edge 24
        reset_b = 1'b1;
        nextFrame();
        reset_b  = 1'b0;
        spawn_b  = 1'b1;
        score_b  = 10'd100;
        pointY_b = 10'd100;
        nextFrame();
        checkOutput("b2b accept slot0", spawnAccepted_b, 1);
        score_b = 10'd104;
        nextFrame();
        checkOutput("b2b accept slot1", spawnAccepted_b, 1);
        checkOutput("b2b activeCount", activeCount_b, 2);
        checkOutput("b2b pipeX1", pipeX_b[19:10], 650);
        spawn_b = 1'b0;
        repeat (22) nextFrame();
        checkOutput("b2b edge23 endOfMapPipe", endOfMapPipe_b, 0);
        checkOutput("b2b edge23 activeCount", activeCount_b, 2);
        nextFrame();
        checkOutput("b2b edge24 endOfMapPipe", endOfMapPipe_b, 1);
        checkOutput("b2b edge24 retireCount", retireCount_b, 2);
        checkOutput("b2b edge24 activeCount", activeCount_b, 0);
        nextFrame();
        checkOutput("b2b edge25 endOfMapPipe", endOfMapPipe_b, 0);
        checkOutput("b2b edge25 retireCount", retireCount_b, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
